i2s_rx: RTL
===========

Name: i2s_rx

Overview:
- Receive side of the Pmod I2S2 link. Deserializes the CS5343 ADC data line (SDOUT) into signed left/right sample pairs.
- Lives in the clk_98_3mhz domain, next to the I2S transmitter. That transmitter generates SCLK/LRCK (48 SCLK per LRCK period, 24-bit slots); this block consumes copies of those strobes.
- Output feeds the vocoder analysis path as one valid-qualified stereo pair per LRCK frame.

Parameters:
- WIDTH, 24, sample width and slot length in SCLK periods (bits per channel slot).
- SYNC_STAGES, 2, synchronizer depth applied identically to sclk_in, lrck_in and sdout_in (minimum 2).

Ports:
- clk_in  input  1  system clock (98.333 MHz).
- rst_in  input  1  reset; synchronous, active-high.
- sclk_in  input  1  I2S bit clock copy, at most clk_in/4, any duty cycle with high and low phases each ≥2 clk_in cycles.
- lrck_in  input  1  I2S word select; 0 = left, 1 = right; changes only while sclk_in is low.
- sdout_in  input  1  ADC serial data (off-chip, asynchronous).
- sample_l_out  output  WIDTH  signed left sample, two's complement.
- sample_r_out  output  WIDTH  signed right sample, two's complement.
- sample_valid_out  output  1  one-cycle strobe; both sample outputs update together in this cycle.
- frame_err_out  output  1  one-cycle strobe on a malformed slot.

Behaviour:
- Reset values: sample_l_out = 0, sample_r_out = 0, sample_valid_out = 0, frame_err_out = 0. Internal state on reset: state = SYNC, bit count = 0, shift register = 0, left-held flag = 0.
- Synchronization: all three inputs pass through SYNC_STAGES flops, giving equal delay and preserved alignment.
- Bit sampling: a bit event is a 0→1 transition of the synchronized SCLK. On each bit event:
  - shift synchronized SDOUT into a WIDTH-bit register, MSB first;
  - latch synchronized LRCK.
- Boundary: a bit event whose LRCK differs from the LRCK latched at the previous bit event.
  - I2S one-bit delay: the boundary bit is the LSB of the word from the previous slot.
  - After that shift, the register holds the complete previous word.
  - The word's channel is the previous LRCK value.
- Bit counter: counts bit events since the last boundary, including the boundary event itself. It saturates at WIDTH+1 and restarts at 1 on each boundary.
- States:
  - SYNC: after reset; waits for the first boundary without emitting anything. At the first boundary → RUN, with bit count = 1.
  - RUN: at each boundary:
    - if count == WIDTH, deliver the word;
    - otherwise pulse frame_err_out, discard the word, and clear the left-held flag. Stay in RUN.
- Delivery:
  - Left word: store it in a holding register and set the left-held flag.
  - Right word with left-held set: on the next cycle, load sample_l_out from the holding register and sample_r_out from the word, pulse sample_valid_out, and clear the flag.
  - Right word without left-held: dropped silently, no error.
  - Left word while left-held is already set: overwrites the held value (no error).
- Latency: sample_valid_out is high in the cycle after clk_in edge number SYNC_STAGES+1, where edge 0 is the first edge that captures sclk_in high at the boundary bit. frame_err_out has the same timing.
- Pulse width: outputs hold between strobes, and each strobe is exactly one cycle.
- Reset mid-frame: state returns to SYNC and the partial word is lost. The first valid pair is the first complete left-then-right pair after the second boundary following reset release.
- LRCK never toggling: no output and no error. The counter saturates, and the first boundary after that raises frame_err_out.

Decomposition:
- Add I2S_WIDTH = 24 and I2S_SCLK_PER_FRAME = 48 to the shared constants package. WIDTH defaults to I2S_WIDTH.
- Add i2s_state_t (SYNC, RUN) to the same package.
- One natural sub-module: sync_edge. It is a SYNC_STAGES-deep synchronizer with a registered rising-edge pulse output.
- sync_edge is instantiated for SCLK. LRCK and SDOUT use its synchronizer path without the edge pulse, so all three stay equally delayed.

Test Plan:
- Nominal pair:
  - Stimulus: SCLK period 10 clk_in cycles; after one sync frame, left word 24'h7FFFFF and right word 24'h800001, I2S one-bit delay.
  - Required: one sample_valid_out pulse with sample_l_out = 24'h7FFFFF and sample_r_out = 24'h800001 (−8388607); frame_err_out stays 0.
- Continuous stream:
  - Stimulus: 100 frames with left = n and right = −n.
  - Required: exactly 99 valid pulses (first frame consumed by SYNC), each pair matching in order, spaced 480 clk_in cycles apart.
- Short slot:
  - Stimulus: one left slot of 23 bits, followed by normal slots.
  - Required: one frame_err_out pulse at the short slot's closing boundary, and that frame produces no valid pulse; the next complete pair is correct.
- Mid-frame reset:
  - Stimulus: assert rst_in for 3 cycles in the middle of a right slot.
  - Required: all outputs read 0 during and after reset, no pulse until the SYNC boundary, and the first pulse carries the first fully received left/right pair.
- Latency:
  - Stimulus: align the boundary SCLK edge to a known clk_in edge.
  - Required: sample_valid_out is high in the cycle after edge SYNC_STAGES+1 (cycle after edge 3 for SYNC_STAGES=2).
- Unaligned start:
  - Stimulus: release reset while lrck_in = 1 mid-slot.
  - Required: no frame_err_out; the first valid pair arrives after one full left-then-right sequence.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared constants and types for the Pmod I2S2 receive path.
package i2s_rx_pkg;

  localparam int I2S_WIDTH          = 24;
  localparam int I2S_SCLK_PER_FRAME = 48;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Multi-stage synchronizer for one strobe plus companion data bits, with a
// registered rising-edge pulse on the strobe and data delayed to match it.
module i2s_rx_sync_edge #(
  parameter int STAGES = 2,
  parameter int N      = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         edge_in,
  input  logic [N-1:0] data_in,
  output logic         rise,
  output logic [N-1:0] data_out
);

  logic [STAGES-1:0]        edge_sync_reg;
  logic [STAGES-1:0][N-1:0] data_sync_reg;
  logic                     edge_last_reg;
  logic                     rise_reg;
  logic [N-1:0]             data_out_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      edge_sync_reg <= '0;
      data_sync_reg <= '0;
      edge_last_reg <= 1'b0;
      rise_reg      <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      edge_sync_reg <= {edge_sync_reg[STAGES-2:0], edge_in};
      data_sync_reg <= {data_sync_reg[STAGES-2:0], data_in};
      edge_last_reg <= edge_sync_reg[STAGES-1];
      rise_reg      <= edge_sync_reg[STAGES-1] & ~edge_last_reg;
      // Extra stage keeps data aligned with the registered edge pulse.
      data_out_reg  <= data_sync_reg[STAGES-1];
    end
  end

  assign rise     = rise_reg;
  assign data_out = data_out_reg;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes the CS5343 SDOUT line into signed stereo pairs,
// one valid strobe per LRCK frame, with a strobe on malformed slots.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int WIDTH       = I2S_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sclk_in,
  input  logic                    lrck_in,
  input  logic                    sdout_in,
  output logic signed [WIDTH-1:0] sample_l_out,
  output logic signed [WIDTH-1:0] sample_r_out,
  output logic                    sample_valid_out,
  output logic                    frame_err_out
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic             bit_evt;
  logic [1:0]       data_sync;
  logic             lrck_s;
  logic             sdout_s;

  i2s_rx_sync_edge #(
    .STAGES (SYNC_STAGES),
    .N      (2)
  ) u_sync (
    .clk      (clk_in),
    .srst     (rst_in),
    .edge_in  (sclk_in),
    .data_in  ({sdout_in, lrck_in}),
    .rise     (bit_evt),
    .data_out (data_sync)
  );

  assign lrck_s  = data_sync[0];
  assign sdout_s = data_sync[1];

  i2s_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] hold_reg;
  logic             held_reg;
  logic             lr_last_reg;
  logic             lr_ref_reg;
  logic             boundary;

  assign shift_next = {shift_reg[WIDTH-2:0], sdout_s};
  // The first bit event after reset only establishes the LRCK reference, so
  // a reset released mid-slot never looks like a boundary.
  assign boundary   = bit_evt && lr_ref_reg && (lrck_s != lr_last_reg);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= SYNC;
      cnt_reg          <= '0;
      shift_reg        <= '0;
      hold_reg         <= '0;
      held_reg         <= 1'b0;
      lr_last_reg      <= 1'b0;
      lr_ref_reg       <= 1'b0;
      sample_l_out     <= '0;
      sample_r_out     <= '0;
      sample_valid_out <= 1'b0;
      frame_err_out    <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      frame_err_out    <= 1'b0;
      if (bit_evt) begin
        shift_reg   <= shift_next;
        lr_last_reg <= lrck_s;
        lr_ref_reg  <= 1'b1;
        if (boundary) begin
          cnt_reg <= CNT_W'(1);
          case (state_reg)
            SYNC: state_reg <= RUN;
            RUN: begin
              if (cnt_reg == CNT_FULL) begin
                // The word just completed belongs to the previous LRCK channel.
                if (!lr_last_reg) begin
                  hold_reg <= shift_next;
                  held_reg <= 1'b1;
                end else if (held_reg) begin
                  sample_l_out     <= hold_reg;
                  sample_r_out     <= shift_next;
                  sample_valid_out <= 1'b1;
                  held_reg         <= 1'b0;
                end
              end else begin
                frame_err_out <= 1'b1;
                held_reg      <= 1'b0;
              end
            end
            default: state_reg <= SYNC;
          endcase
        end else if (cnt_reg != CNT_SAT) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule
